// File: rtl/phj_pkg.sv
// phj_pkg: shared types and defaults for the partitioned hash join release controller.
package phj_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} phj_rc_state_t;
  localparam int NUM_CH_DEF = 8;
  localparam int SEQ_W_DEF  = 32;
endpackage

// File: rtl/phj_sat_counter.sv
// phj_sat_counter: counter that saturates at all-ones, with clear taking priority over increment.
module phj_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);
  logic [W-1:0] cnt_q;
  always_comb nxt_o = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= resetn ? nxt_o : '0;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/phj_release_ctrl.sv
// phj_release_ctrl: lock-step release of one tuple from every enabled SaR channel,
// with release sequencing, end-of-run detection and stall monitoring.
module phj_release_ctrl
  import phj_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SEQ_W       = SEQ_W_DEF,
  parameter int STALL_W     = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [NUM_CH-1:0]  ch_enable_i,
  input  logic [NUM_CH-1:0]  in_is_stored_i,
  input  logic [NUM_CH-1:0]  out_ready_i,
  input  logic [NUM_CH-1:0]  local_last_processed_i,
  output logic [NUM_CH-1:0]  release_data_o,
  output logic [SEQ_W-1:0]   next_seq_o,
  output logic               last_processed_o,
  output logic               busy_o,
  output logic [STALL_W-1:0] stall_cycles_o,
  output logic               stall_flag_o
);
  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);
  phj_rc_state_t      state_q, state_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               flag_q;
  logic               fire, finish, stall, go, held;
  logic [STALL_W-1:0] stall_nxt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      en_q    <= '0;
      seq_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      seq_q   <= seq_d;
      flag_q  <= stall_nxt >= LIMIT;
    end
  end
  // Disabled channels are forced to "satisfied" so they never block release or finish.
  always_comb begin
    held    = |(in_is_stored_i & en_q);
    fire    = (state_q == RUN) && (&(in_is_stored_i | ~en_q)) && (&(out_ready_i | ~en_q));
    finish  = (state_q == RUN) && (&(local_last_processed_i | ~en_q)) && !held && !fire;
    stall   = (state_q == RUN) && !fire && held;
    go      = start_i && (state_q != RUN);
    en_d    = go ? ch_enable_i : en_q;
    seq_d   = go ? '0 : fire ? seq_q + SEQ_W'(1) : seq_q;
    state_d = go ? ((|ch_enable_i) ? RUN : DONE) : finish ? DONE : state_q;
  end
  always_comb begin
    release_data_o   = fire ? en_q : '0;
    busy_o           = state_q == RUN;
    last_processed_o = state_q == DONE;
  end
  phj_sat_counter #(.W(STALL_W)) u_stall (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (stall),
    .clr_i  (!stall || go),
    .cnt_o  (stall_cycles_o),
    .nxt_o  (stall_nxt)
  );
  assign next_seq_o   = seq_q;
  assign stall_flag_o = flag_q;
endmodule
